axi4_lite_req_arbiter: RTL and testbench

//  Shares one AXI4-Lite master engine between N requesters via round-robin arbitration.

---
 rtl/axi4_lite_pkg.sv | 18 +
 rtl/axi4_lite_req_arbiter_if.sv | 49 ++++
 rtl/axi4_lite_req_arbiter_rr_arbiter.sv | 36 +++
 rtl/axi4_lite_req_arbiter.sv | 169 ++++++++++++++++
 tb/tb_axi4_lite_req_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite request arbiter.
//  - RESP_* : AXI4-Lite RRESP/BRESP encodings.
//  - arb_state_t : arbiter FSM states, also exported on the dbg_state port.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/axi4_lite_req_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the AXI4-Lite master engine.
//  Requester side : rq_valid/rq_ready/rq_write/rq_addr/rq_wdata, rs_valid/rs_rdata/rs_resp
//  Engine side    : start_read/start_write/address/data
//  Snooped AXI    : M_AXI_R*/M_AXI_B* handshakes, read data and responses
//  modport slave  : the arbiter's view; modport master : the environment's view.
// Handshake rule: a command transfers in the cycle where rq_valid[i] & rq_ready[i] is high;
// rq_valid may be dropped before that cycle, and rs_valid is a one-cycle pulse with no
// back-pressure.
interface axi4_lite_req_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]    rq_valid;
  logic [N_REQ-1:0]    rq_ready;
  logic [N_REQ-1:0]    rq_write;
  logic [N_REQ*AW-1:0] rq_addr;
  logic [N_REQ*DW-1:0] rq_wdata;
  logic [N_REQ-1:0]    rs_valid;
  logic [DW-1:0]       rs_rdata;
  logic [1:0]          rs_resp;
  logic                start_read;
  logic                start_write;
  logic [AW-1:0]       address;
  logic [DW-1:0]       data;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;
  logic [DW-1:0]       M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [1:0]          M_AXI_BRESP;

  modport slave (
    input  rq_valid, rq_write, rq_addr, rq_wdata,
    input  M_AXI_RVALID, M_AXI_RREADY, M_AXI_RDATA, M_AXI_RRESP,
    input  M_AXI_BVALID, M_AXI_BREADY, M_AXI_BRESP,
    output rq_ready, rs_valid, rs_rdata, rs_resp,
    output start_read, start_write, address, data
  );

  modport master (
    output rq_valid, rq_write, rq_addr, rq_wdata,
    output M_AXI_RVALID, M_AXI_RREADY, M_AXI_RDATA, M_AXI_RRESP,
    output M_AXI_BVALID, M_AXI_BREADY, M_AXI_BRESP,
    input  rq_ready, rs_valid, rs_rdata, rs_resp,
    input  start_read, start_write, address, data
  );
endinterface

// File: rtl/axi4_lite_req_arbiter_rr_arbiter.sv
// Round-robin grant: picks the first asserted request after index 'last', scanning
// upward with wrap-around. Purely combinational.
//  req     in  N   request vector
//  last    in  PW  index of the previously served requester
//  gnt     out N   one-hot grant (zero when no request)
//  gnt_idx out PW  index of the granted requester (0 when no request)
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Offsets 1..N visit every index once, ending on 'last' itself.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one AXI4-Lite master engine between N_REQ requesters.
// One command is accepted at a time (round-robin among valid requesters), the engine
// is kicked with a one-cycle start pulse while address/data stay stable, and completion
// is detected by snooping the R or B handshake matching the command type.
//  ACLK, ARESET  : clock and synchronous active-high reset
//  bus           : requester, engine and snooped AXI signals (slave modport)
//  busy          : high in every state except IDLE
//  wdog_timeout  : sticky, set once WAIT has lasted WDOG_CYCLES cycles (0 disables)
//  dbg_state     : current FSM state
module axi4_lite_req_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WDOG_CYCLES   = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi4_lite_req_arbiter_if.slave bus,
  output logic                  busy,
  output logic                  wdog_timeout,
  output arb_state_t            dbg_state
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(N_REQ);
  localparam int WW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic              write_q, write_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [AW-1:0]     address_q, address_d;
  logic [DW-1:0]     data_q, data_d;
  logic              start_read_q, start_read_d;
  logic              start_write_q, start_write_d;
  logic [N_REQ-1:0]  rs_valid_q, rs_valid_d;
  logic [DW-1:0]     rs_rdata_q, rs_rdata_d;
  logic [1:0]        rs_resp_q, rs_resp_d;
  logic              busy_q, busy_d;
  logic [WW-1:0]     wdog_cnt_q, wdog_cnt_d;
  logic              wdog_timeout_q, wdog_timeout_d;

  logic [N_REQ-1:0]  gnt;
  logic [PW-1:0]     gnt_idx;
  logic [N_REQ-1:0]  rq_ready_w;
  logic              accept;
  logic              done;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req     (bus.rq_valid),
    .last    (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Only rq_ready is combinational; it follows the live grant while idle.
  assign rq_ready_w = (state_q == ARB_IDLE) ? gnt : '0;
  assign accept     = |(bus.rq_valid & rq_ready_w);
  // Only the handshake matching the owner's command type completes it.
  assign done       = write_q ? (bus.M_AXI_BVALID & bus.M_AXI_BREADY)
                              : (bus.M_AXI_RVALID & bus.M_AXI_RREADY);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    write_d        = write_q;
    rr_d           = rr_q;
    address_d      = address_q;
    data_d         = data_q;
    start_read_d   = 1'b0;
    start_write_d  = 1'b0;
    rs_valid_d     = '0;
    rs_rdata_d     = rs_rdata_q;
    rs_resp_d      = rs_resp_q;
    wdog_cnt_d     = wdog_cnt_q;
    wdog_timeout_d = wdog_timeout_q;

    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          state_d       = ARB_ISSUE;
          owner_d       = gnt_idx;
          write_d       = bus.rq_write[gnt_idx];
          address_d     = bus.rq_addr[int'(gnt_idx)*AW +: AW];
          data_d        = bus.rq_wdata[int'(gnt_idx)*DW +: DW];
          // Registered, so the pulse is visible during ISSUE.
          start_read_d  = ~bus.rq_write[gnt_idx];
          start_write_d = bus.rq_write[gnt_idx];
        end
      end
      ARB_ISSUE: begin
        state_d    = ARB_WAIT;
        wdog_cnt_d = '0;
      end
      ARB_WAIT: begin
        if (done) begin
          state_d             = ARB_RESP;
          rs_valid_d[owner_q] = 1'b1;
          rs_rdata_d          = write_q ? '0 : bus.M_AXI_RDATA;
          rs_resp_d           = write_q ? bus.M_AXI_BRESP : bus.M_AXI_RRESP;
        end else if (WDOG_CYCLES != 0 && wdog_cnt_q != WDOG_MAX) begin
          // Saturates at WDOG_MAX; the FSM keeps waiting for the engine.
          wdog_cnt_d = wdog_cnt_q + WW'(1);
          if (wdog_cnt_d == WDOG_MAX) begin
            wdog_timeout_d = 1'b1;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        rr_d    = owner_q;
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q        <= ARB_IDLE;
      owner_q        <= '0;
      write_q        <= 1'b0;
      rr_q           <= PW'(N_REQ - 1);
      address_q      <= '0;
      data_q         <= '0;
      start_read_q   <= 1'b0;
      start_write_q  <= 1'b0;
      rs_valid_q     <= '0;
      rs_rdata_q     <= '0;
      rs_resp_q      <= RESP_OKAY;
      busy_q         <= 1'b0;
      wdog_cnt_q     <= '0;
      wdog_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      write_q        <= write_d;
      rr_q           <= rr_d;
      address_q      <= address_d;
      data_q         <= data_d;
      start_read_q   <= start_read_d;
      start_write_q  <= start_write_d;
      rs_valid_q     <= rs_valid_d;
      rs_rdata_q     <= rs_rdata_d;
      rs_resp_q      <= rs_resp_d;
      busy_q         <= busy_d;
      wdog_cnt_q     <= wdog_cnt_d;
      wdog_timeout_q <= wdog_timeout_d;
    end
  end

  assign bus.rq_ready    = rq_ready_w;
  assign bus.rs_valid    = rs_valid_q;
  assign bus.rs_rdata    = rs_rdata_q;
  assign bus.rs_resp     = rs_resp_q;
  assign bus.start_read  = start_read_q;
  assign bus.start_write = start_write_q;
  assign bus.address     = address_q;
  assign bus.data        = data_q;
  assign busy            = busy_q;
  assign wdog_timeout    = wdog_timeout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Bench for axi4_lite_req_arbiter: directed scenarios plus a randomized phase, all checked
// against a transaction-level model (round-robin pick, accept/start/done/response timeline,
// expected-response queue).
module tb_axi4_lite_req_arbiter;
  import axi4_lite_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WD = 8;
  localparam int EW = N + DW + 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic       wdog_timeout;
  arb_state_t dbg_state;

  always #5 clk = ~clk;

  axi4_lite_req_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  axi4_lite_req_arbiter #(
    .N_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WDOG_CYCLES(WD)
  ) dut (
    .ACLK         (clk),
    .ARESET       (rst),
    .bus          (bus.slave),
    .busy         (busy),
    .wdog_timeout (wdog_timeout),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int own = -1;          // requester owning the engine, -1 when idle
  int age = 0;           // cycles since accept (accept cycle = 0)
  int delay = 0;         // WAIT cycles before the engine completes
  int last_g = N - 1;    // last served requester
  int acc_idx_prev = -1;
  bit acc_prev = 0;
  bit done_prev = 0;
  bit completed = 0;
  bit sticky = 0;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;

  // stimulus knobs
  bit            rand_req = 1'b0;
  bit            hold_valid = 1'b0;
  bit            noise_en = 1'b0;
  bit            fix_eng = 1'b0;
  int            fixed_delay = -1;
  logic [DW-1:0] fix_rdata = '0;
  logic [1:0]    fix_resp = '0;
  logic [N-1:0]  dir_valid = '0;
  logic [N-1:0]  dir_write = '0;
  logic [AW-1:0] dir_addr [N];
  logic [DW-1:0] dir_data [N];

  // observations
  int            grants[$];
  int            completions = 0;
  int            starts_r = 0;
  int            starts_w = 0;
  logic [N-1:0]  last_rs_valid;
  logic [DW-1:0] last_rdata;
  logic [1:0]    last_resp;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_requesters(input int acc_idx);
    if (rand_req) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.rq_valid[i] || acc_idx == i) begin
          bus.rq_valid[i]            = ($urandom_range(0, 1) == 1);
          bus.rq_write[i]            = ($urandom_range(0, 1) == 1);
          bus.rq_addr[i*AW +: AW]    = $urandom();
          bus.rq_wdata[i*DW +: DW]   = $urandom();
        end else if ($urandom_range(0, 7) == 0) begin
          bus.rq_valid[i] = 1'b0;
        end
      end
    end else begin
      bus.rq_valid = dir_valid;
      bus.rq_write = dir_write;
      for (int i = 0; i < N; i++) begin
        bus.rq_addr[i*AW +: AW]  = dir_addr[i];
        bus.rq_wdata[i*DW +: DW] = dir_data[i];
      end
    end
  endtask

  task automatic drive_engine(output bit completing);
    bit           waiting;
    int           r;
    logic [N-1:0] oh;
    logic [DW-1:0] rd;
    logic [1:0]   rsp;
    bus.M_AXI_RDATA  = $urandom();
    bus.M_AXI_RRESP  = 2'($urandom_range(0, 3));
    bus.M_AXI_BRESP  = 2'($urandom_range(0, 3));
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RREADY = 1'b0;
    bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BREADY = 1'b0;
    waiting    = (own != -1) && !completed && (age >= 2);
    completing = waiting && (age == 2 + delay);
    if (completing) begin
      if (fix_eng) begin
        bus.M_AXI_RDATA = fix_rdata;
        bus.M_AXI_RRESP = fix_resp;
        bus.M_AXI_BRESP = fix_resp;
      end
      if (cmd_write) {bus.M_AXI_BVALID, bus.M_AXI_BREADY} = 2'b11;
      else           {bus.M_AXI_RVALID, bus.M_AXI_RREADY} = 2'b11;
      oh      = '0;
      oh[own] = 1'b1;
      rd      = cmd_write ? '0 : bus.M_AXI_RDATA;
      rsp     = cmd_write ? bus.M_AXI_BRESP : bus.M_AXI_RRESP;
      exp_q.push_back({oh, rd, rsp});
      completed = 1'b1;
    end else if (noise_en) begin
      r = $urandom_range(0, 3);
      if (waiting) begin
        // wrong-type handshake, or the right type with only one side high
        case (r)
          1: if (cmd_write) {bus.M_AXI_RVALID, bus.M_AXI_RREADY} = 2'b11;
             else           {bus.M_AXI_BVALID, bus.M_AXI_BREADY} = 2'b11;
          2: if (cmd_write) bus.M_AXI_BVALID = 1'b1; else bus.M_AXI_RVALID = 1'b1;
          3: if (cmd_write) bus.M_AXI_BREADY = 1'b1; else bus.M_AXI_RREADY = 1'b1;
          default: ;
        endcase
      end else begin
        case (r)
          1: {bus.M_AXI_RVALID, bus.M_AXI_RREADY} = 2'b11;
          2: {bus.M_AXI_BVALID, bus.M_AXI_BREADY} = 2'b11;
          3: {bus.M_AXI_RVALID, bus.M_AXI_RREADY, bus.M_AXI_BVALID, bus.M_AXI_BREADY} = 4'hF;
          default: ;
        endcase
      end
    end
  endtask

  // One clock cycle: check registered outputs, drive new inputs, check rq_ready.
  task automatic step();
    bit           completing;
    bit           resp_now;
    int           w;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    if (own != -1) age++;
    if (own != -1 && !completed && age >= 2 + WD) sticky = 1'b1;
    check("start_read", bus.start_read, acc_prev && !cmd_write);
    check("start_write", bus.start_write, acc_prev && cmd_write);
    if (bus.start_read)  starts_r++;
    if (bus.start_write) starts_w++;
    resp_now = done_prev;
    if (done_prev) begin
      check("rs_bundle", {bus.rs_valid, bus.rs_rdata, bus.rs_resp}, exp_q.pop_front());
      last_rs_valid = bus.rs_valid;
      last_rdata    = bus.rs_rdata;
      last_resp     = bus.rs_resp;
      completions++;
      last_g = own;
    end else begin
      check("rs_valid_quiet", bus.rs_valid, '0);
    end
    check("busy", busy, own != -1);
    check("wdog_timeout", wdog_timeout, sticky);
    if (own != -1) begin
      check("address_hold", bus.address, cmd_addr);
      check("data_hold", bus.data, cmd_data);
    end
    drive_requesters(acc_idx_prev);
    drive_engine(completing);
    #1;
    w = (own == -1) ? rr_pick(bus.rq_valid, last_g) : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("rq_ready", bus.rq_ready, exp_rdy);
    if (resp_now) begin
      own       = -1;
      completed = 1'b0;
    end
    acc_prev     = 1'b0;
    acc_idx_prev = -1;
    if (w >= 0) begin
      own          = w;
      age          = 0;
      cmd_write    = bus.rq_write[w];
      cmd_addr     = bus.rq_addr[w*AW +: AW];
      cmd_data     = bus.rq_wdata[w*DW +: DW];
      delay        = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 4);
      acc_prev     = 1'b1;
      acc_idx_prev = w;
      grants.push_back(w);
      if (!rand_req && !hold_valid) dir_valid[w] = 1'b0;
    end
    done_prev = completing;
  endtask

  task automatic run_until(input int target, input int budget);
    int start;
    start = completions;
    for (int c = 0; c < budget && (completions - start) < target; c++) step();
    check("txn_count", completions - start, target);
  endtask

  task automatic apply_reset(input int n);
    bus.rq_valid     = '0;
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RREADY = 1'b0;
    bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BREADY = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst          = 1'b0;
    own          = -1;
    age          = 0;
    last_g       = N - 1;
    acc_prev     = 1'b0;
    acc_idx_prev = -1;
    done_prev    = 1'b0;
    completed    = 1'b0;
    sticky       = 1'b0;
    exp_q.delete();
    check("rst_rq_ready", bus.rq_ready, '0);
    check("rst_rs_valid", bus.rs_valid, '0);
    check("rst_rs_rdata", bus.rs_rdata, '0);
    check("rst_rs_resp", bus.rs_resp, '0);
    check("rst_start_read", bus.start_read, 1'b0);
    check("rst_start_write", bus.start_write, 1'b0);
    check("rst_address", bus.address, '0);
    check("rst_data", bus.data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_wdog", wdog_timeout, 1'b0);
    check("rst_state", dbg_state, ARB_IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.rq_write    = '0;
    bus.rq_addr     = '0;
    bus.rq_wdata    = '0;
    bus.M_AXI_RDATA = '0;
    bus.M_AXI_RRESP = '0;
    bus.M_AXI_BRESP = '0;
    for (int i = 0; i < N; i++) begin
      dir_addr[i] = '0;
      dir_data[i] = '0;
    end
    apply_reset(2);

    // Single read from requester 0
    fix_eng = 1'b1; fix_rdata = 32'hDEADBEEF; fix_resp = RESP_OKAY; fixed_delay = 2;
    dir_valid = 3'b001; dir_write = 3'b000; dir_addr[0] = 32'h10; dir_data[0] = 32'h0;
    starts_r = 0; starts_w = 0;
    run_until(1, 50);
    check("t1_rs_valid", last_rs_valid, 3'b001);
    check("t1_rdata", last_rdata, 32'hDEADBEEF);
    check("t1_resp", last_resp, RESP_OKAY);
    check("t1_start_reads", starts_r, 1);
    check("t1_start_writes", starts_w, 0);

    // Single write from requester 1 with spurious read handshakes around it
    noise_en = 1'b1; fix_resp = RESP_SLVERR; fixed_delay = 4;
    dir_valid = 3'b010; dir_write = 3'b010; dir_addr[1] = 32'h20; dir_data[1] = 32'h1234;
    starts_r = 0; starts_w = 0;
    run_until(1, 50);
    check("t2_rs_valid", last_rs_valid, 3'b010);
    check("t2_rdata", last_rdata, 32'h0);
    check("t2_resp", last_resp, RESP_SLVERR);
    check("t2_start_writes", starts_w, 1);
    check("t2_start_reads", starts_r, 0);

    // Contention between requesters 0 and 1 held valid
    fix_eng = 1'b0; fixed_delay = -1; hold_valid = 1'b1;
    dir_valid = 3'b011; dir_write = 3'b010;
    grants.delete();
    run_until(4, 200);
    for (int k = 0; k < 4; k++)
      check("t3_grant_order", (k < grants.size()) ? grants[k] : -1, k % 2);
    hold_valid = 1'b0; dir_valid = '0;

    // Reset while the engine is pending
    dir_valid = 3'b100; dir_write = 3'b000; dir_addr[2] = 32'h300; fixed_delay = 100;
    for (int c = 0; c < 50 && !(own != -1 && age >= 4); c++) step();
    check("t5_reached_wait", (own != -1) && (age >= 4), 1'b1);
    dir_valid = '0;
    apply_reset(1);
    dir_valid = 3'b101; dir_write = 3'b001; dir_addr[0] = 32'h40; dir_data[0] = 32'h55;
    fixed_delay = 1;
    grants.delete();
    run_until(2, 100);
    check("t5_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    check("t5_second_grant", (grants.size() > 1) ? grants[1] : -1, 2);

    // Randomized traffic
    rand_req = 1'b1; fixed_delay = -1; noise_en = 1'b1;
    run_until(150, 5000);
    rand_req = 1'b0; dir_valid = '0;
    run_until(0, 0);
    for (int c = 0; c < 20 && own != -1; c++) step();

    // Watchdog: engine never completes
    dir_valid = 3'b010; dir_write = 3'b000; fixed_delay = 1000;
    repeat (25) step();
    check("t6_wdog_final", wdog_timeout, 1'b1);
    check("t6_busy", busy, 1'b1);
    check("t6_state", dbg_state, ARB_WAIT);
    dir_valid = '0;
    apply_reset(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
